power_gesture_ctrl: RTL and testbench

Parametrised power-state controller for the board front panel. It debounces `NUM_BTN` raw push-buttons and keeps a single `power_status` bit. Power is switched by a short press (on) or long press (off) of button 0, or by configurable two-button gestures inside a timed window. An optional idle auto-off timer is included. It sits between the raw button pins and the display/menu logic, which consume `power_status` and the per-button press pulses.

---
 rtl/power_gesture_ctrl.sv | 131 +++++++++++++
 tb/tb_power_gesture_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_gesture_ctrl.sv
// Front-panel power controller: debounced buttons, short/long press on button 0, two-button gestures, idle auto-off.
// Latency: btn_in to btn_stable is 2 + DEBOUNCE_CYC cycles; no backpressure, all events are one-cycle pulses.
module power_gesture_ctrl #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYC    = 20_000_000,
    parameter int LONG_PRESS_CYC  = 300_000_000,
    parameter int GESTURE_WIN_CYC = 500_000_000,
    parameter int IDLE_OFF_CYC    = 0,
    parameter int ON_FIRST        = 1,
    parameter int ON_SECOND       = 2,
    parameter int OFF_FIRST       = 2,
    parameter int OFF_SECOND      = 1,
    parameter int CNT_W           = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic               power_status,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               long_press,
    output logic               gesture_armed,
    output logic               idle_off
);

    typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYC);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(GESTURE_WIN_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_OFF_CYC - 1);
    localparam logic             IDLE_EN   = (IDLE_OFF_CYC > 0);

    logic [NUM_BTN-1:0] sync1_q, sync2_q, stable_q, stable_d, prev_q;
    logic [CNT_W-1:0]   deb_q [NUM_BTN];
    logic [CNT_W-1:0]   deb_d [NUM_BTN];
    logic [CNT_W-1:0]   hold_q, hold_d, win_q, win_d, idle_q, idle_d;
    logic               long_q, long_d, armed_q, armed_d, idle_off_q, idle_off_d;
    state_t             state_q, state_d;

    logic [NUM_BTN-1:0] press;
    logic fall0, long_hit, press_first, press_second, complete, expire;
    logic quiet, idle_hit, on_cause, off_cause;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
                else                      deb_d[i]    = deb_q[i] + 1'b1;
            end
        end
    end

    // hold_q holds the number of earlier stable-high cycles, so the pulse lands on the LONG_PRESS_CYC-th one
    always_comb begin
        press    = stable_q & ~prev_q;
        fall0    = prev_q[0] & ~stable_q[0];
        long_hit = stable_q[0] & (hold_q == LONG_LAST);
        hold_d   = '0;
        if (stable_q[0]) hold_d = (hold_q == LONG_SAT) ? hold_q : hold_q + 1'b1;
        long_d   = fall0 ? 1'b0 : (long_q | long_hit);
    end

    always_comb begin
        press_first  = (state_q == ON) ? press[OFF_FIRST]  : press[ON_FIRST];
        press_second = (state_q == ON) ? press[OFF_SECOND] : press[ON_SECOND];
        complete     = armed_q & press_second;
        expire       = armed_q & (win_q == WIN_LAST);
        quiet        = ~(|press) & ~stable_q[0];
        idle_hit     = IDLE_EN & (state_q == ON) & quiet & (idle_q == IDLE_LAST);
        on_cause     = (fall0 & ~long_q) | (complete & (state_q == OFF));
        off_cause    = long_hit | (complete & (state_q == ON)) | idle_hit;

        state_d = state_q;
        if (state_q == OFF && on_cause)  state_d = ON;
        if (state_q == ON  && off_cause) state_d = OFF;

        // completion outranks both re-arm and expiry in the same cycle
        armed_d = armed_q;
        win_d   = '0;
        if (state_d != state_q || complete) armed_d = 1'b0;
        else if (press_first)               armed_d = 1'b1;
        else if (expire)                    armed_d = 1'b0;
        else if (armed_q)                   win_d   = win_q + 1'b1;

        idle_d     = '0;
        if (IDLE_EN && state_q == ON && quiet && !idle_hit) idle_d = idle_q + 1'b1;
        idle_off_d = idle_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            for (int i = 0; i < NUM_BTN; i++) deb_q[i] <= '0;
            hold_q     <= '0;
            long_q     <= 1'b0;
            win_q      <= '0;
            armed_q    <= 1'b0;
            idle_q     <= '0;
            idle_off_q <= 1'b0;
            state_q    <= OFF;
        end else begin
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            for (int i = 0; i < NUM_BTN; i++) deb_q[i] <= deb_d[i];
            hold_q     <= hold_d;
            long_q     <= long_d;
            win_q      <= win_d;
            armed_q    <= armed_d;
            idle_q     <= idle_d;
            idle_off_q <= idle_off_d;
            state_q    <= state_d;
        end
    end

    assign power_status  = (state_q == ON);
    assign btn_stable    = stable_q;
    assign btn_press     = press;
    assign long_press    = long_hit;
    assign gesture_armed = armed_q;
    assign idle_off      = idle_off_q;

endmodule

// File: tb/tb_power_gesture_ctrl.sv
// Directed bench for power_gesture_ctrl: stimulus queues expected output changes, a monitor checks each one.
module tb_power_gesture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_in;
    logic       power_status, long_press, gesture_armed, idle_off;
    logic [2:0] btn_stable, btn_press;

    power_gesture_ctrl #(
        .NUM_BTN(3), .DEBOUNCE_CYC(4), .LONG_PRESS_CYC(20), .GESTURE_WIN_CYC(10),
        .IDLE_OFF_CYC(50), .ON_FIRST(1), .ON_SECOND(2), .OFF_FIRST(2), .OFF_SECOND(1), .CNT_W(30)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .power_status(power_status),
        .btn_stable(btn_stable), .btn_press(btn_press), .long_press(long_press),
        .gesture_armed(gesture_armed), .idle_off(idle_off)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed vector: {power, armed, idle_off, long_press, press[2:0], stable[2:0]}
    typedef struct {
        int         t;
        logic [9:0] v;
    } ev_t;
    ev_t q[$];

    int checks = 0;
    int fails  = 0;
    logic mon_en = 1'b0;
    logic mon_started = 1'b0;
    logic [9:0] mon_obs, mon_last;
    ev_t mon_e;

    task automatic ex(input int t, input logic p, input logic a, input logic i, input logic l,
                      input logic [2:0] pr, input logic [2:0] st);
        ev_t e;
        e.t = t;
        e.v = {p, a, i, l, pr, st};
        q.push_back(e);
    endtask

    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_obs = {power_status, gesture_armed, idle_off, long_press, btn_press, btn_stable};
            if (!mon_started) begin
                checks++;
                if (mon_obs !== 10'b0) begin
                    fails++;
                    $display("FAIL reset_state: got %b, want %b", mon_obs, 10'b0);
                end
                mon_started = 1'b1;
                mon_last    = mon_obs;
            end else if (mon_obs !== mon_last) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, want no change", mon_obs, cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.v !== mon_obs || mon_e.t != cyc) begin
                        fails++;
                        $display("FAIL output_event: got %b at cycle %0d, want %b at cycle %0d",
                                 mon_obs, cyc, mon_e.v, mon_e.t);
                    end
                end
                mon_last = mon_obs;
            end
        end
    end

    // short press of button 0 starting at b: stable b+6..b+11, power on at b+13
    task automatic short_on(input int b);
        ex(b+6,  0, 0, 0, 0, 3'b001, 3'b001);
        ex(b+7,  0, 0, 0, 0, 3'b000, 3'b001);
        ex(b+12, 0, 0, 0, 0, 3'b000, 3'b000);
        ex(b+13, 1, 0, 0, 0, 3'b000, 3'b000);
        btn_in[0] = 1'b1;
        at(b+6);
        btn_in[0] = 1'b0;
    endtask

    initial begin
        int b;
        rst    = 1'b1;
        btn_in = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        at(cyc + 2);

        // bounce then short press: only the final 10-cycle hold is accepted
        b = cyc;
        ex(b+14, 0, 0, 0, 0, 3'b001, 3'b001);
        ex(b+15, 0, 0, 0, 0, 3'b000, 3'b001);
        ex(b+24, 0, 0, 0, 0, 3'b000, 3'b000);
        ex(b+25, 1, 0, 0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 5; k++) begin
            btn_in[0] = (k % 2 == 0);
            at(b + 2*k + 2);
        end
        at(b+18); btn_in[0] = 1'b0;
        at(b+30);

        // long press while ON: pulse on 20th stable cycle, release ignored
        b = cyc;
        ex(b+6,  1, 0, 0, 0, 3'b001, 3'b001);
        ex(b+7,  1, 0, 0, 0, 3'b000, 3'b001);
        ex(b+25, 1, 0, 0, 1, 3'b000, 3'b001);
        ex(b+26, 0, 0, 0, 0, 3'b000, 3'b001);
        ex(b+36, 0, 0, 0, 0, 3'b000, 3'b000);
        btn_in[0] = 1'b1;
        at(b+30); btn_in[0] = 1'b0;
        at(b+40);

        // gesture on: button 1 then button 2 five cycles later
        b = cyc;
        ex(b+6,  0, 0, 0, 0, 3'b010, 3'b010);
        ex(b+7,  0, 1, 0, 0, 3'b000, 3'b010);
        ex(b+11, 0, 1, 0, 0, 3'b100, 3'b110);
        ex(b+12, 1, 0, 0, 0, 3'b000, 3'b100);
        ex(b+17, 1, 0, 0, 0, 3'b000, 3'b000);
        btn_in[1] = 1'b1;
        at(b+5);  btn_in[2] = 1'b1;
        at(b+6);  btn_in[1] = 1'b0;
        at(b+11); btn_in[2] = 1'b0;
        at(b+20);

        // gesture off: arm with 2, then 1+2 together on the last window cycle
        b = cyc;
        ex(b+6,  1, 0, 0, 0, 3'b100, 3'b100);
        ex(b+7,  1, 1, 0, 0, 3'b000, 3'b100);
        ex(b+12, 1, 1, 0, 0, 3'b000, 3'b000);
        ex(b+16, 1, 1, 0, 0, 3'b110, 3'b110);
        ex(b+17, 0, 0, 0, 0, 3'b000, 3'b110);
        ex(b+22, 0, 0, 0, 0, 3'b000, 3'b000);
        btn_in[2] = 1'b1;
        at(b+6);  btn_in[2] = 1'b0;
        at(b+10); btn_in[1] = 1'b1; btn_in[2] = 1'b1;
        at(b+16); btn_in[1] = 1'b0; btn_in[2] = 1'b0;
        at(b+25);

        // OFF and unarmed, 1+2 together: arms only, then window expires
        b = cyc;
        ex(b+6,  0, 0, 0, 0, 3'b110, 3'b110);
        ex(b+7,  0, 1, 0, 0, 3'b000, 3'b110);
        ex(b+12, 0, 1, 0, 0, 3'b000, 3'b000);
        ex(b+17, 0, 0, 0, 0, 3'b000, 3'b000);
        btn_in[1] = 1'b1; btn_in[2] = 1'b1;
        at(b+6); btn_in[1] = 1'b0; btn_in[2] = 1'b0;
        at(b+20);

        // gesture on with a 12-cycle gap: window closed, second press ignored
        b = cyc;
        ex(b+6,  0, 0, 0, 0, 3'b010, 3'b010);
        ex(b+7,  0, 1, 0, 0, 3'b000, 3'b010);
        ex(b+12, 0, 1, 0, 0, 3'b000, 3'b000);
        ex(b+17, 0, 0, 0, 0, 3'b000, 3'b000);
        ex(b+18, 0, 0, 0, 0, 3'b100, 3'b100);
        ex(b+19, 0, 0, 0, 0, 3'b000, 3'b100);
        ex(b+24, 0, 0, 0, 0, 3'b000, 3'b000);
        btn_in[1] = 1'b1;
        at(b+6);  btn_in[1] = 1'b0;
        at(b+12); btn_in[2] = 1'b1;
        at(b+18); btn_in[2] = 1'b0;
        at(b+28);

        // idle auto-off after 50 quiet ON cycles
        b = cyc;
        short_on(b);
        ex(b+63, 0, 0, 1, 0, 3'b000, 3'b000);
        ex(b+64, 0, 0, 0, 0, 3'b000, 3'b000);
        at(b+66);

        // press on ON-cycle 40 restarts the idle count
        b = cyc;
        short_on(b);
        ex(b+53,  1, 0, 0, 0, 3'b010, 3'b010);
        ex(b+54,  1, 0, 0, 0, 3'b000, 3'b010);
        ex(b+59,  1, 0, 0, 0, 3'b000, 3'b000);
        ex(b+104, 0, 0, 1, 0, 3'b000, 3'b000);
        ex(b+105, 0, 0, 0, 0, 3'b000, 3'b000);
        at(b+47);  btn_in[1] = 1'b1;
        at(b+53);  btn_in[1] = 1'b0;
        at(b+108);

        // reset while ON, armed and button 0 held 15 cycles; button stays held through reset
        b = cyc;
        short_on(b);
        ex(b+22, 1, 0, 0, 0, 3'b001, 3'b001);
        ex(b+23, 1, 0, 0, 0, 3'b000, 3'b001);
        ex(b+30, 1, 0, 0, 0, 3'b100, 3'b101);
        ex(b+31, 1, 1, 0, 0, 3'b000, 3'b101);
        ex(b+36, 1, 1, 0, 0, 3'b000, 3'b001);
        ex(b+37, 0, 0, 0, 0, 3'b000, 3'b000);
        ex(b+43, 0, 0, 0, 0, 3'b001, 3'b001);
        ex(b+44, 0, 0, 0, 0, 3'b000, 3'b001);
        ex(b+51, 0, 0, 0, 0, 3'b000, 3'b000);
        ex(b+52, 1, 0, 0, 0, 3'b000, 3'b000);
        at(b+16); btn_in[0] = 1'b1;
        at(b+24); btn_in[2] = 1'b1;
        at(b+30); btn_in[2] = 1'b0;
        at(b+36); rst = 1'b1;
        at(b+37); rst = 1'b0;
        at(b+45); btn_in[0] = 1'b0;
        at(b+60);

        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_event: got nothing, want %b at cycle %0d", mon_e.v, mon_e.t);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
